// File: rtl/fc_weight_loader_pkg.sv
// Shared FC-layer constants: weight geometry, counter widths and the loader state encoding.
// Also used by the FC layer datapath and its pool-result packing.
package fc_pkg;

  localparam int WEIGHT_WIDTH = 32;
  localparam int N_IN         = 1152;
  localparam int N_OUT        = 10;
  localparam int TOTAL_WORDS  = N_IN * N_OUT;
  localparam int CNT_W        = 14;
  localparam int IDX_W        = $clog2(N_IN);
  localparam int NRN_W        = $clog2(N_OUT);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(N_OUT - 1);
  localparam logic [NRN_W-1:0] NRN_ONE  = NRN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fc_weight_loader_bank.sv
// One neuron's worth of weight registers: single write port, all entries driven out as a flat bus.
// Outputs are direct register values with no read latency.
module fc_weight_bank
  import fc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [WEIGHT_WIDTH-1:0]      wr_data,
  output logic [N_IN*WEIGHT_WIDTH-1:0] weights
);

  logic [WEIGHT_WIDTH-1:0] mem [N_IN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_flat
    assign weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem[i];
  end

endmodule

// File: rtl/fc_weight_loader.sv
// Loads N_OUT x N_IN signed weights, neuron-major, from a valid/ready word stream into register banks.
// Sticky load_err on bad framing; weights_valid only once a full set ends exactly on s_last.
module fc_weight_loader
  import fc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         s_valid,
  input  logic [WEIGHT_WIDTH-1:0]      s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic                         weights_valid,
  output logic                         load_err,
  output logic [CNT_W-1:0]             words_loaded,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_0_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_1_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_2_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_3_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_4_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_5_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_6_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_7_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_8_f,
  output logic [N_IN*WEIGHT_WIDTH-1:0] fc_weight_9_f
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NRN_W-1:0]   nrn_q, nrn_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               err_q, err_d;
  logic               wr_en;
  logic               final_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nrn_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nrn_q   <= nrn_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nrn_d      = nrn_q;
    words_d    = words_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    final_word = (nrn_q == NRN_LAST) && (idx_q == IDX_LAST);

    // start overrides any word presented in the same cycle
    if (start) begin
      state_d = LOAD;
      idx_d   = '0;
      nrn_d   = '0;
      words_d = '0;
      err_d   = 1'b0;
    end else if (state_q == LOAD && s_valid) begin
      if (s_last && !final_word) begin
        // premature end of set: drop the word and abort
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        wr_en   = 1'b1;
        words_d = words_q + CNT_ONE;
        if (final_word) begin
          state_d = s_last ? DONE : IDLE;
          err_d   = !s_last;
        end else if (idx_q == IDX_LAST) begin
          idx_d = '0;
          nrn_d = nrn_q + NRN_ONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
    end
  end

  assign s_ready       = (state_q == LOAD);
  assign weights_valid = (state_q == DONE);
  assign load_err      = err_q;
  assign words_loaded  = words_q;

  logic [N_IN*WEIGHT_WIDTH-1:0] bank_w [N_OUT];

  for (genvar k = 0; k < N_OUT; k++) begin : g_bank
    fc_weight_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en && (nrn_q == NRN_W'(k))),
      .wr_idx  (idx_q),
      .wr_data (s_data),
      .weights (bank_w[k])
    );
  end

  assign fc_weight_0_f = bank_w[0];
  assign fc_weight_1_f = bank_w[1];
  assign fc_weight_2_f = bank_w[2];
  assign fc_weight_3_f = bank_w[3];
  assign fc_weight_4_f = bank_w[4];
  assign fc_weight_5_f = bank_w[5];
  assign fc_weight_6_f = bank_w[6];
  assign fc_weight_7_f = bank_w[7];
  assign fc_weight_8_f = bank_w[8];
  assign fc_weight_9_f = bank_w[9];

endmodule

// File: tb/tb_fc_weight_loader.sv
// Randomized bench for fc_weight_loader: flat-array reference of the weight set plus a scoreboard
// of expected end-of-load outcomes checked by a monitor on weights_valid / load_err rising.
module tb_fc_weight_loader;

  localparam int W     = 32;
  localparam int NI    = 1152;
  localparam int NO    = 10;
  localparam int TOTAL = NI * NO;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          weights_valid;
  logic          load_err;
  logic [13:0]   words_loaded;
  logic [NI*W-1:0] fc_w [NO];

  fc_weight_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .weights_valid (weights_valid),
    .load_err      (load_err),
    .words_loaded  (words_loaded),
    .fc_weight_0_f (fc_w[0]),
    .fc_weight_1_f (fc_w[1]),
    .fc_weight_2_f (fc_w[2]),
    .fc_weight_3_f (fc_w[3]),
    .fc_weight_4_f (fc_w[4]),
    .fc_weight_5_f (fc_w[5]),
    .fc_weight_6_f (fc_w[6]),
    .fc_weight_7_f (fc_w[7]),
    .fc_weight_8_f (fc_w[8]),
    .fc_weight_9_f (fc_w[9])
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    bit err;
    int words;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] ref_w [TOTAL];
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Word n of the stream belongs to neuron n / NI at position n % NI.
  task automatic compare_all(input string tag);
    for (int k = 0; k < NO; k++) begin
      int bad = 0;
      for (int i = 0; i < NI; i++)
        if (fc_w[k][i*W +: W] !== ref_w[k*NI + i]) bad++;
      check($sformatf("%s bus%0d mismatching weights", tag, k), 32'(bad), 32'd0);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < TOTAL; n++) ref_w[n] = '0;
  endtask

  // Monitor: a load outcome appears when weights_valid or load_err rises.
  bit wv_prev = 1'b0;
  bit le_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && ((weights_valid && !wv_prev) || (load_err && !le_prev))) begin
      if (exp_q.size() == 0) begin
        check("unexpected load outcome", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("outcome weights_valid", 32'(weights_valid), 32'(e.valid));
        check("outcome load_err", 32'(load_err), 32'(e.err));
        check("outcome words_loaded", 32'(words_loaded), 32'(e.words));
        check("outcome s_ready", 32'(s_ready), 32'd0);
        compare_all("outcome");
      end
    end
    wv_prev = weights_valid;
    le_prev = load_err;
  end

  task automatic wait_drain(input string tag);
    int c = 0;
    while (exp_q.size() != 0 && c < 4) begin
      @(posedge clk); #1;
      c++;
    end
    check($sformatf("%s outcome seen", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic pulse_start(input bit with_word);
    start = 1'b1;
    s_valid = with_word;
    s_data = 32'hDEAD_BEEF;
    s_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b0;
    check("start weights_valid", 32'(weights_valid), 32'd0);
    check("start load_err", 32'(load_err), 32'd0);
    check("start words_loaded", 32'(words_loaded), 32'd0);
    check("start s_ready", 32'(s_ready), 32'd1);
  endtask

  // Present word n; optional random idle cycles first. Model follows the framing rules.
  task automatic send(input int n, input logic [W-1:0] d, input bit last, input bit gaps);
    bit early;
    early = last && (n != TOTAL - 1);
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (early || n == TOTAL - 1)
      exp_q.push_back('{valid: (last && !early), err: (early || !last), words: (early ? n : n + 1)});
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    check("s_ready while loading", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    if (!early) ref_w[n] = d;
  endtask

  initial begin
    logic [W-1:0] fd;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset s_ready", 32'(s_ready), 32'd0);
    check("reset weights_valid", 32'(weights_valid), 32'd0);
    check("reset load_err", 32'(load_err), 32'd0);
    check("reset words_loaded", 32'(words_loaded), 32'd0);
    compare_all("reset");

    // full back-to-back load, data = n
    pulse_start(1'b0);
    for (int n = 0; n < TOTAL; n++) send(n, W'(n), n == TOTAL - 1, 1'b0);
    check("t1 weights_valid after last", 32'(weights_valid), 32'd1);
    check("t1 s_ready after last", 32'(s_ready), 32'd0);
    check("t1 words_loaded", 32'(words_loaded), 32'd11520);
    check("t1 w3_5", fc_w[3][5*W +: W], 32'd3461);
    check("t1 w9_1151", fc_w[9][1151*W +: W], 32'd11519);
    wait_drain("t1");

    // words presented in DONE are ignored
    s_valid = 1'b1;
    s_data = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("done ignore weights_valid", 32'(weights_valid), 32'd1);
    check("done ignore words_loaded", 32'(words_loaded), 32'd11520);
    compare_all("done ignore");

    // same load with random gaps, data = -n
    pulse_start(1'b0);
    for (int n = 0; n < TOTAL; n++) send(n, W'(-n), n == TOTAL - 1, 1'b1);
    check("t2 w0_0", fc_w[0][0 +: W], 32'd0);
    check("t2 w1_0", fc_w[1][0 +: W], 32'hFFFF_FB80);
    wait_drain("t2");

    // reload from DONE with 7; second start mid-load carries a word that must be dropped
    pulse_start(1'b0);
    pulse_start(1'b1);
    compare_all("start wins");
    for (int n = 0; n < TOTAL; n++) send(n, 32'd7, n == TOTAL - 1, 1'b0);
    wait_drain("t5");

    // s_last on word 100
    pulse_start(1'b0);
    for (int n = 0; n <= 100; n++) send(n, $urandom(), n == 100, 1'b0);
    check("t3 load_err", 32'(load_err), 32'd1);
    check("t3 s_ready", 32'(s_ready), 32'd0);
    check("t3 words_loaded", 32'(words_loaded), 32'd100);
    check("t3 w0_100 kept", fc_w[0][100*W +: W], 32'd7);
    wait_drain("t3");

    // words presented in IDLE are ignored, error stays
    s_valid = 1'b1;
    s_last = 1'b1;
    s_data = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    check("idle ignore load_err", 32'(load_err), 32'd1);
    check("idle ignore words_loaded", 32'(words_loaded), 32'd100);
    compare_all("idle ignore");

    // reset mid-load
    pulse_start(1'b0);
    for (int n = 0; n < 5000; n++) send(n, $urandom(), 1'b0, 1'b0);
    check("t4 words before reset", 32'(words_loaded), 32'd5000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("t4 s_ready", 32'(s_ready), 32'd0);
    check("t4 weights_valid", 32'(weights_valid), 32'd0);
    check("t4 load_err", 32'(load_err), 32'd0);
    check("t4 words_loaded", 32'(words_loaded), 32'd0);
    compare_all("t4");

    // final word without s_last
    pulse_start(1'b0);
    fd = $urandom();
    for (int n = 0; n < TOTAL; n++) send(n, (n == TOTAL - 1) ? fd : W'($urandom()), 1'b0, 1'b0);
    check("t6 load_err", 32'(load_err), 32'd1);
    check("t6 weights_valid", 32'(weights_valid), 32'd0);
    check("t6 w9_1151", fc_w[9][1151*W +: W], fd);
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
